// File: rtl/ctrl_pkg.sv
// Shared control encodings for the multi-cycle CPU sequencer: opcodes, FSM
// state codes, ALU operation codes and the opcode decode helper.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_HALT   = 3'd6;
    localparam state_t ST_ERROR  = 3'd7;

    typedef struct packed {
        logic       legal;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       wb_sel_mem;
    } dec_t;

    // Address generation for LW/SW uses ADD; BEQ compares via SUB.
    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        d = '{legal: 1'b1, alu_op: ALU_ADD, alu_src_imm: 1'b0, wb_sel_mem: 1'b0};
        case (op)
            OP_NOP, OP_ADD, OP_J, OP_HALT: ;
            OP_SUB, OP_BEQ: d.alu_op = ALU_SUB;
            OP_AND:         d.alu_op = ALU_AND;
            OP_OR:          d.alu_op = ALU_OR;
            OP_ADDI, OP_SW: d.alu_src_imm = 1'b1;
            OP_LW: begin
                d.alu_src_imm = 1'b1;
                d.wb_sel_mem  = 1'b1;
            end
            default:        d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog for a pending memory request: counts waiting cycles since the last
// clear and flags expiry on the MEM_TIMEOUT-th cycle without an ack.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // count_q holds how many cycles have already been waited before this one.
    assign expired = (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state updates use non-blocking assignments so every flop
    // samples the pre-edge values; combinational blocks use blocking ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with PC strobes,
// register write control and watchdog-guarded memory handshakes.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_load,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        reg_write,
    output logic        wb_sel_mem,
    output logic        pc_en,
    output logic        is_branch,
    output logic        is_jump,
    output logic        halted,
    output logic        error
);

    import ctrl_pkg::*;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] opcode_q;
    logic [3:0] opcode_d;
    dec_t       dec;
    logic       waiting;
    logic       timer_clear;
    logic       timer_expired;
    logic       in_instr;
    logic       unused_instr;

    // Only the opcode field is consumed here; operands go to the datapath.
    assign unused_instr = ^instr[27:0];

    assign dec = decode_op(opcode_q);

    // NOTE: every always_comb output gets a default first, so no path through
    // the case statements can leave a value held and infer a latch.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    opcode_d = instr[31:28];
                    state_d  = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (!dec.legal) begin
                    state_d = ST_ERROR;
                end else if (opcode_q == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode_q)
                    OP_NOP, OP_BEQ, OP_J: state_d = ST_FETCH;
                    OP_LW, OP_SW:         state_d = ST_MEM;
                    default:              state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = (opcode_q == OP_SW) ? ST_FETCH : ST_WB;
                end else if (timer_expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // The watchdog restarts on every state entry, so FETCH and MEM share it.
    assign waiting     = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_clear = (state_d != state_q) || !waiting;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (waiting),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= OP_NOP;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Outputs decode the registered state so an async reset clears them at once.
    assign in_instr = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                      (state_q == ST_MEM)    || (state_q == ST_WB);

    assign imem_req    = (state_q == ST_FETCH);
    assign ir_load     = (state_q == ST_FETCH) && imem_ack;
    assign dmem_req    = (state_q == ST_MEM);
    assign dmem_we     = (state_q == ST_MEM) && (opcode_q == OP_SW);
    assign alu_op      = in_instr ? dec.alu_op : ALU_ADD;
    assign alu_src_imm = in_instr && dec.alu_src_imm;
    assign wb_sel_mem  = in_instr && dec.wb_sel_mem;
    assign reg_write   = (state_q == ST_WB);
    assign is_branch   = (state_q == ST_EXEC) && (opcode_q == OP_BEQ);
    assign is_jump     = (state_q == ST_EXEC) && (opcode_q == OP_J);
    assign halted      = (state_q == ST_HALT);
    assign error       = (state_q == ST_ERROR);

    // Exactly one retirement strobe per instruction, whichever state retires it.
    assign pc_en = (state_q == ST_WB) ||
                   ((state_q == ST_EXEC) && ((opcode_q == OP_NOP) ||
                                             (opcode_q == OP_BEQ) ||
                                             (opcode_q == OP_J))) ||
                   ((state_q == ST_MEM) && dmem_ack && (opcode_q == OP_SW));

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: table-driven per-cycle vectors fed
// through an expected-value queue, plus hand sequences for reset/timeout/halt.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] instr;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        ir_load;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_write;
    logic        wb_sel_mem;
    logic        pc_en;
    logic        is_branch;
    logic        is_jump;
    logic        halted;
    logic        error;

    int tests_run = 0;
    int tests_failed = 0;

    // Output bundle layout: [15]imem_req [14]dmem_req [13]dmem_we [12]ir_load
    // [11:9]alu_op [8]alu_src_imm [7]reg_write [6]wb_sel_mem [5]pc_en
    // [4]is_branch [3]is_jump [2]halted [1]error [0]zero
    localparam logic [15:0] IREQ = 16'h8000;
    localparam logic [15:0] DREQ = 16'h4000;
    localparam logic [15:0] WE   = 16'h2000;
    localparam logic [15:0] IRL  = 16'h1000;
    localparam logic [15:0] SUB  = 16'h0200;
    localparam logic [15:0] ANDO = 16'h0400;
    localparam logic [15:0] IMM  = 16'h0100;
    localparam logic [15:0] RW   = 16'h0080;
    localparam logic [15:0] WBM  = 16'h0040;
    localparam logic [15:0] PC   = 16'h0020;
    localparam logic [15:0] BR   = 16'h0010;
    localparam logic [15:0] JP   = 16'h0008;
    localparam logic [15:0] HLT  = 16'h0004;
    localparam logic [15:0] ERR  = 16'h0002;
    localparam logic [3:0]  GRB  = 4'hE;

    typedef struct {
        logic        st;
        logic        iack;
        logic [3:0]  op;
        logic        dack;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    logic [15:0] act;

    assign act = {imem_req, dmem_req, dmem_we, ir_load, alu_op, alu_src_imm,
                  reg_write, wb_sel_mem, pc_en, is_branch, is_jump, halted,
                  error, 1'b0};

    cpu_control_fsm #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .ir_load     (ir_load),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_write   (reg_write),
        .wb_sel_mem  (wb_sel_mem),
        .pc_en       (pc_en),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .halted      (halted),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: outputs got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, queue the expectation,
    // then compare the DUT outputs 1 ns later, well before the rising edge.
    task automatic step(input string name, input logic st, input logic iack,
                        input logic [3:0] op, input logic dack, input logic [15:0] exp);
        @(negedge clk);
        start    = st;
        imem_ack = iack;
        instr    = {op, 28'h0000123};
        dmem_ack = dack;
        exp_q.push_back(exp);
        #1;
        check(name, act, exp_q.pop_front());
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check(name, act, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add(input logic st, input logic iack, input logic [3:0] op,
                       input logic dack, input logic [15:0] exp);
        vecs.push_back('{st: st, iack: iack, op: op, dack: dack, exp: exp});
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        instr    = '0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // IDLE -> ADD, SUB, ADDI, LW (late fetch ack, 3 MEM waits), SW, BEQ, J, NOP, AND
        add(1, 0, GRB, 0, 16'h0000);
        add(0, 1, 4'h1, 0, IREQ | IRL);
        add(0, 0, GRB, 0, 16'h0000);
        add(0, 0, GRB, 0, 16'h0000);
        add(0, 0, GRB, 0, RW | PC);
        add(0, 1, 4'h2, 0, IREQ | IRL);
        add(0, 0, GRB, 0, SUB);
        add(0, 0, GRB, 0, SUB);
        add(0, 0, GRB, 0, SUB | RW | PC);
        add(0, 1, 4'h5, 0, IREQ | IRL);
        add(0, 0, GRB, 0, IMM);
        add(0, 0, GRB, 0, IMM);
        add(0, 0, GRB, 0, IMM | RW | PC);
        add(0, 0, GRB, 0, IREQ);
        add(0, 1, 4'h6, 0, IREQ | IRL);
        add(0, 0, GRB, 0, IMM | WBM);
        add(0, 0, GRB, 0, IMM | WBM);
        add(0, 0, GRB, 0, DREQ | IMM | WBM);
        add(0, 0, GRB, 0, DREQ | IMM | WBM);
        add(0, 0, GRB, 0, DREQ | IMM | WBM);
        add(0, 0, GRB, 1, DREQ | IMM | WBM);
        add(0, 0, GRB, 0, IMM | WBM | RW | PC);
        add(0, 1, 4'h7, 0, IREQ | IRL);
        add(0, 0, GRB, 0, IMM);
        add(0, 0, GRB, 0, IMM);
        add(0, 0, GRB, 0, DREQ | WE | IMM);
        add(0, 0, GRB, 1, DREQ | WE | IMM | PC);
        add(0, 1, 4'h8, 0, IREQ | IRL);
        add(0, 0, GRB, 0, SUB);
        add(0, 0, GRB, 0, SUB | PC | BR);
        add(0, 1, 4'h9, 0, IREQ | IRL);
        add(0, 0, GRB, 0, 16'h0000);
        add(0, 0, GRB, 0, PC | JP);
        add(0, 1, 4'h0, 0, IREQ | IRL);
        add(0, 1, GRB, 1, 16'h0000);
        add(0, 1, GRB, 1, PC);
        add(0, 1, 4'h3, 0, IREQ | IRL);
        add(0, 0, GRB, 0, ANDO);
        add(0, 0, GRB, 0, ANDO);
        add(0, 0, GRB, 0, ANDO | RW | PC);

        #2;
        check("reset_state", act, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].st, vecs[i].iack, vecs[i].op,
                 vecs[i].dack, vecs[i].exp);
        end

        // Fetch watchdog: 4 cycles without imem_ack, then sticky ERROR.
        for (int i = 0; i < 4; i++) step($sformatf("fetch_wait%0d", i), 0, 0, GRB, 0, IREQ);
        step("fetch_timeout", 1, 1, 4'h1, 1, ERR);
        step("error_sticky0", 1, 1, 4'h1, 1, ERR);
        step("error_sticky1", 0, 0, GRB, 0, ERR);
        do_reset("reset_from_error");

        // Illegal opcode 0xB traps after DECODE with no pc_en.
        step("illegal_idle", 1, 0, GRB, 0, 16'h0000);
        step("illegal_fetch", 0, 1, 4'hB, 0, IREQ | IRL);
        step("illegal_decode", 0, 0, GRB, 0, 16'h0000);
        step("illegal_error", 0, 0, GRB, 0, ERR);
        step("illegal_sticky", 0, 1, 4'h1, 0, ERR);
        do_reset("reset_after_illegal");

        // Reset asserted in the middle of a MEM wait drops dmem_req immediately.
        step("mid_idle", 1, 0, GRB, 0, 16'h0000);
        step("mid_fetch", 0, 1, 4'h6, 0, IREQ | IRL);
        step("mid_decode", 0, 0, GRB, 0, IMM | WBM);
        step("mid_exec", 0, 0, GRB, 0, IMM | WBM);
        step("mid_mem", 0, 0, GRB, 0, DREQ | IMM | WBM);
        #1;
        reset = 1'b1;
        #1;
        check("reset_mid_mem", act, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step("restart_idle", 1, 0, GRB, 0, 16'h0000);
        step("restart_fetch", 0, 0, GRB, 0, IREQ);

        // Data-memory watchdog: LW whose ack never comes.
        step("memto_fetch", 0, 1, 4'h6, 0, IREQ | IRL);
        step("memto_decode", 0, 0, GRB, 0, IMM | WBM);
        step("memto_exec", 0, 0, GRB, 0, IMM | WBM);
        for (int i = 0; i < 4; i++) step($sformatf("memto_wait%0d", i), 0, 0, GRB, 0, DREQ | IMM | WBM);
        step("memto_error", 0, 0, GRB, 1, ERR);
        do_reset("reset_after_mem_timeout");

        // HALT is sticky: no requests or PC strobes despite start and acks.
        step("halt_idle", 1, 0, GRB, 0, 16'h0000);
        step("halt_fetch", 1, 1, 4'hF, 0, IREQ | IRL);
        step("halt_decode", 1, 1, GRB, 1, 16'h0000);
        for (int i = 0; i < 20; i++) step($sformatf("halt_hold%0d", i), 1, 1, 4'h1, 1, HLT);
        do_reset("reset_from_halt");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
